// File: rtl/scan_display_pkg.sv
// Shared types and constants for the scanned hex display.
// SEG_HEX holds active-low segment patterns, bit order gfedcba, indexed by nibble value.
package scan_display_pkg;

   typedef logic [6:0] seg7_t;

   localparam seg7_t SEG_BLANK = 7'h7F;

   localparam seg7_t SEG_HEX [16] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000,   // 9
      7'b0001000,   // A
      7'b0000011,   // b
      7'b1000110,   // C
      7'b0100001,   // d
      7'b0000110,   // E
      7'b0001110    // F
   };

endpackage

// File: rtl/scan_hex_display_if.sv
// Bus between a datapath and the scanned hex display.
// The master side supplies digits, decimal points, load strobe and blanking.
// The slave side (the display driver) returns segment, decimal point, anode and frame tick.
interface scan_hex_display_if #(
   parameter int NUM_DIGITS = 8
);

   logic [4*NUM_DIGITS-1:0] value_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic [6:0]              seg_out;
   logic                    dp_out;
   logic [NUM_DIGITS-1:0]   an_out;
   logic                    frame_tick;

   modport master (
      output value_in, dp_in, load, blank_in,
      input  seg_out, dp_out, an_out, frame_tick
   );

   modport slave (
      input  value_in, dp_in, load, blank_in,
      output seg_out, dp_out, an_out, frame_tick
   );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
// Any nibble that does not match a defined hex value leaves the digit dark.
module seg7_hex_decode
   import scan_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   output seg7_t      seg_o
);

   // Table lookup by explicit compare so unknown inputs fall through to blank.
   always_comb begin
      seg_o = SEG_BLANK;
      for (int i = 0; i < 16; i++) begin
         if (nibble_i == 4'(i)) begin
            seg_o = SEG_HEX[i];
         end
      end
   end

endmodule

// File: rtl/scan_hex_display.sv
// Time-multiplexed N-digit hex display driver for common-anode boards.
// Values are loaded into a pending buffer and only become visible at a frame
// boundary, so a frame never mixes old and new digits. Each digit slot begins
// with a few dark cycles to avoid ghosting on the previous digit's anode.
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN (darkens leading zero digits).
module scan_hex_display
   import scan_display_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input logic               Clk,
   input logic               Rst,
   scan_hex_display_if.slave disp
);

   localparam int SLOT_W = $clog2(SLOT_CYCLES);
   localparam int DIG_W  = $clog2(NUM_DIGITS);

   logic [SLOT_W-1:0]       slotCnt_q, slotCnt_d;
   logic [DIG_W-1:0]        digIdx_q, digIdx_d;
   logic [4*NUM_DIGITS-1:0] pendVal_q, pendVal_d;
   logic [NUM_DIGITS-1:0]   pendDp_q, pendDp_d;
   logic                    pendValid_q, pendValid_d;
   logic [4*NUM_DIGITS-1:0] shownVal_q, shownVal_d;
   logic [NUM_DIGITS-1:0]   shownDp_q, shownDp_d;
   logic                    frameStart_q;
   logic                    frameTick_q;
   seg7_t                   seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;

   logic                    slotLast;
   logic                    digLast;
   logic                    frameWrap;
   logic [3:0]              curNibble;
   seg7_t                   decSeg;
   logic                    inBlankWin;
   logic                    suppress;
   logic                    digDark;

   assign slotLast   = (slotCnt_q == SLOT_W'(SLOT_CYCLES - 1));
   assign digLast    = (digIdx_q == DIG_W'(NUM_DIGITS - 1));
   assign frameWrap  = slotLast && digLast;
   assign curNibble  = shownVal_q[{digIdx_q, 2'b00} +: 4];
   assign inBlankWin = (slotCnt_q < SLOT_W'(BLANK_CYCLES));

   seg7_hex_decode u_decode (
      .nibble_i (curNibble),
      .seg_o    (decSeg)
   );

`ifdef LEADING_ZERO_SUPPRESS_EN
   logic [DIG_W-1:0] keepTop;

   // Highest digit that must stay lit: top nonzero nibble or top lit decimal point, never below digit 0.
   always_comb begin
      keepTop = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if ((shownVal_q[4*i +: 4] != 4'h0) || shownDp_q[i]) begin
            keepTop = DIG_W'(i);
         end
      end
      suppress = (digIdx_q > keepTop);
   end
`else
   assign suppress = 1'b0;
`endif

   assign digDark = disp.blank_in[digIdx_q] | suppress;

   // Prescaler and digit counter advance: slot counter wraps, then the digit index steps.
   always_comb begin
      slotCnt_d = slotLast ? '0 : slotCnt_q + SLOT_W'(1);
      digIdx_d  = digIdx_q;
      if (slotLast) begin
         digIdx_d = digLast ? '0 : digIdx_q + DIG_W'(1);
      end
   end

   // Pending/shown buffering: promote at frame wrap, and a same-cycle load refills pending.
   always_comb begin
      pendVal_d   = pendVal_q;
      pendDp_d    = pendDp_q;
      pendValid_d = pendValid_q;
      shownVal_d  = shownVal_q;
      shownDp_d   = shownDp_q;
      if (frameWrap && pendValid_q) begin
         shownVal_d  = pendVal_q;
         shownDp_d   = pendDp_q;
         pendValid_d = 1'b0;
      end
      if (disp.load) begin
         pendVal_d   = disp.value_in;
         pendDp_d    = disp.dp_in;
         pendValid_d = 1'b1;
      end
   end

   // Pin values for the current slot: dark during the anti-ghost window or when the digit is dark.
   always_comb begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      an_d  = '1;
      if (!inBlankWin && !digDark) begin
         an_d  = ~(NUM_DIGITS'(1) << digIdx_q);
         seg_d = decSeg;
         dp_d  = ~shownDp_q[digIdx_q];
      end
   end

   // Scan position registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         slotCnt_q <= '0;
         digIdx_q  <= '0;
      end else begin
         slotCnt_q <= slotCnt_d;
         digIdx_q  <= digIdx_d;
      end
   end

   // Pending and shown digit/decimal-point buffers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pendVal_q   <= '0;
         pendDp_q    <= '0;
         pendValid_q <= 1'b0;
         shownVal_q  <= '0;
         shownDp_q   <= '0;
      end else begin
         pendVal_q   <= pendVal_d;
         pendDp_q    <= pendDp_d;
         pendValid_q <= pendValid_d;
         shownVal_q  <= shownVal_d;
         shownDp_q   <= shownDp_d;
      end
   end

   // Output registers; frame tick is delayed one extra stage to line up with digit 0's first output.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         an_q         <= '1;
         frameStart_q <= 1'b0;
         frameTick_q  <= 1'b0;
      end else begin
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         an_q         <= an_d;
         frameStart_q <= frameWrap;
         frameTick_q  <= frameStart_q;
      end
   end

   assign disp.seg_out    = seg_q;
   assign disp.dp_out     = dp_q;
   assign disp.an_out     = an_q;
   assign disp.frame_tick = frameTick_q;

endmodule
